// File: rtl/sopc_bus_arbiter.sv
// sopc_bus_arbiter
// ----------------
// Shares the single-port system memory bus between the CPU instruction-fetch
// port (master 0) and the load/store port (master 1), and raises a pipeline
// stall request while either master is waiting for service.
//
// Handshake: a master raises mN_req with its we/addr/wdata/sel and holds it
// until mN_ack pulses for exactly one cycle. mN_rdata is valid in that cycle,
// and mN_err accompanies the ack when the slave timed out. The master must
// drop or change its request at the edge that ends the ack cycle. On the
// slave side, s_req is high for the whole WAIT phase with stable fields. A
// single-cycle s_ack completes the access, and s_ack outside WAIT is ignored.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   m0_* / m1_*              master request side (req, we, addr, wdata, sel
//                            in; rdata, ack, err out)
//   s_*                      slave side (req, we, addr, wdata, sel out;
//                            rdata, ack in)
//   stallreq                 stall request to the CPU control unit
//   state_dbg                current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module sopc_bus_arbiter #(
  parameter int TIMEOUT = 16  // slave wait-cycle limit, legal 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sel,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_sel,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic        stallreq,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last;   // master served by the most recent completion
  logic       gnt;    // master owning the current transaction
  logic [7:0] cnt;    // WAIT cycles elapsed without s_ack
  logic       pick;   // master to grant if a request is taken this cycle

  // On a conflict, the master not served last wins. Otherwise the lone
  // requester wins.
  assign pick = (m0_req && m1_req) ? ~last : m1_req;

  assign stallreq  = (m0_req & ~m0_ack) | (m1_req & ~m1_ack);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= 1'b0;
      gnt      <= 1'b0;
      cnt      <= 8'd0;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= 32'd0;
      s_wdata  <= 32'd0;
      s_sel    <= 4'd0;
      m0_rdata <= 32'd0;
      m1_rdata <= 32'd0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt     <= pick;
            s_req   <= 1'b1;
            s_we    <= pick ? m1_we    : m0_we;
            s_addr  <= pick ? m1_addr  : m0_addr;
            s_wdata <= pick ? m1_wdata : m0_wdata;
            s_sel   <= pick ? m1_sel   : m0_sel;
            cnt     <= 8'd0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A slave ack in the final allowed cycle still completes normally.
          if (s_ack) begin
            s_req <= 1'b0;
            state <= RESP;
            if (gnt) begin
              m1_rdata <= s_rdata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= s_rdata;
              m0_ack   <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            s_req <= 1'b0;
            state <= RESP;
            if (gnt) begin
              m1_rdata <= 32'd0;
              m1_ack   <= 1'b1;
              m1_err   <= 1'b1;
            end else begin
              m0_rdata <= 32'd0;
              m0_ack   <= 1'b1;
              m0_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_err <= 1'b0;
          last   <= gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// tb_sopc_bus_arbiter
// -------------------
// Directed bench for sopc_bus_arbiter with TIMEOUT = 4. Master drivers issue
// requests and push expected responses. A slave model answers after a
// programmable number of wait cycles and checks the slave-side fields
// against an expected queue. A response monitor pops and compares every
// master ack.
module tb_sopc_bus_arbiter;

  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic [31:0] s_rdata = 0;
  logic        s_ack = 0;
  logic        stallreq;
  logic [1:0]  state_dbg;

  sopc_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sel(m0_sel), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sel(m1_sel), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_sel(s_sel), .s_rdata(s_rdata), .s_ack(s_ack),
    .stallreq(stallreq), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];    // {master, err, rdata}
  logic [68:0] exp_s_q[$];  // {we, addr, wdata, sel}

  int   slv_wait  = 0;      // wait cycles before s_ack, -1 = never
  bit   stray_ack = 0;      // drive s_ack while s_req is low
  int   sreq_len  = 0;      // length of the most recent s_req burst
  int   slv_cnt   = 0;
  int   slv_run   = 0;
  logic [68:0] slv_cur = '0;

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave memory contents: one fixed word, the rest derived from the address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h3401_1100;
    return {~a[15:0], a[15:0]};
  endfunction

  // ---------------- slave model ----------------
  always @(negedge clk) begin
    if (s_req === 1'b1) begin
      if (slv_cnt == 0) begin
        check("slave_queue_nonempty", 96'(exp_s_q.size() != 0), 96'd1);
        slv_cur = (exp_s_q.size() != 0) ? exp_s_q.pop_front() : '0;
      end
      check("slave_fields", {s_we, s_addr, s_wdata, s_sel}, slv_cur);
      slv_run++;
      if (slv_wait >= 0 && slv_cnt == slv_wait) begin
        s_ack   = 1'b1;
        s_rdata = mem_data(s_addr);
      end else begin
        s_ack   = 1'b0;
        s_rdata = 32'hBAD0_BAD0;
      end
      slv_cnt++;
    end else begin
      if (slv_run > 0) sreq_len = slv_run;
      slv_run = 0;
      slv_cnt = 0;
      s_ack   = stray_ack;
      s_rdata = 32'h5555_AAAA;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (m0_ack || m1_ack) begin
        logic [33:0] e;
        check("ack_onehot", 96'(m0_ack & m1_ack), 96'd0);
        check("sb_queue_nonempty", 96'(exp_q.size() != 0), 96'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_response",
                m1_ack ? {1'b1, m1_err, m1_rdata} : {1'b0, m0_err, m0_rdata}, e);
        end
      end else begin
        check("err_without_ack", 96'(m0_err | m1_err), 96'd0);
      end
    end
  end

  // ---------------- master driver ----------------
  task automatic run_master(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sel,
                            input int exp_lat, input bit chk_stall);
    int cnt = 0;
    bit got = 0;
    @(negedge clk);
    if (m == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_sel = sel; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_sel = sel; m1_req = 1'b1;
    end
    if (chk_stall) begin
      #1;
      check("stall_req_cycle", 96'(stallreq), 96'd1);
    end
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if ((m == 0) ? m0_ack : m1_ack) got = 1;
      else if (chk_stall) check("stall_waiting", 96'(stallreq), 96'd1);
    end
    check("ack_seen", 96'(got), 96'd1);
    if (got && exp_lat >= 0) check("ack_latency", 96'(cnt), 96'(exp_lat));
    if (got && chk_stall) check("stall_ack_cycle", 96'(stallreq), 96'd0);
    @(posedge clk);
    #1;
    if (m == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_slave_side", {s_req, s_we, s_addr, s_wdata, s_sel}, '0);
    check("reset_master_side", {m0_rdata, m1_rdata, m0_ack, m1_ack, m0_err, m1_err}, '0);
    check("reset_state", 96'(state_dbg), 96'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, zero-wait slave
    slv_wait = 0;
    exp_s_q.push_back({1'b0, 32'h0000_0010, 32'h0, 4'b1111});
    exp_q.push_back({1'b0, 1'b0, 32'h3401_1100});
    run_master(0, 1'b0, 32'h0000_0010, 32'h0, 4'b1111, 2, 1);

    // Store with 3 wait cycles: s_ack lands on the last allowed WAIT cycle
    slv_wait = 3;
    exp_s_q.push_back({1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111});
    exp_q.push_back({1'b1, 1'b0, 32'hFEFF_0100});
    run_master(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 5, 1);
    check("store_sreq_len", 96'(sreq_len), 96'd4);
    check("m0_rdata_hold", 96'(m0_rdata), 96'h3401_1100);

    // Reset in the middle of WAIT
    slv_wait = -1;
    exp_s_q.push_back({1'b1, 32'h0000_0044, 32'h1234_5678, 4'b1010});
    @(negedge clk);
    m0_we = 1'b1; m0_addr = 32'h0000_0044; m0_wdata = 32'h1234_5678;
    m0_sel = 4'b1010; m0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midwait_sreq", 96'(s_req), 96'd1);
    check("midwait_saddr", 96'(s_addr), 96'h44);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_slave_side", {s_req, s_we, s_addr, s_wdata, s_sel}, '0);
    check("async_reset_master_side",
          {m0_rdata, m1_rdata, m0_ack, m1_ack, m0_err, m1_err}, '0);
    check("async_reset_state", 96'(state_dbg), 96'd0);
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Normal grant after the reset
    slv_wait = 0;
    exp_s_q.push_back({1'b0, 32'h0000_0010, 32'h0, 4'b1111});
    exp_q.push_back({1'b0, 1'b0, 32'h3401_1100});
    run_master(0, 1'b0, 32'h0000_0010, 32'h0, 4'b1111, 2, 1);

    // Timeout with stray slave acks outside WAIT
    slv_wait  = -1;
    stray_ack = 1;
    exp_s_q.push_back({1'b0, 32'h0000_0020, 32'h0, 4'b1111});
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    run_master(0, 1'b0, 32'h0000_0020, 32'h0, 4'b1111, 5, 1);
    check("timeout_sreq_len", 96'(sreq_len), 96'd4);
    check("timeout_back_idle", 96'(state_dbg), 96'd0);
    @(negedge clk);
    check("stray_ack_ignored", {s_req, state_dbg}, '0);
    stray_ack = 0;

    // Conflicts after reset: last = 0, so master 1 goes first
    reset_pulse();
    slv_wait = 1;
    exp_s_q.push_back({1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b0011});
    exp_s_q.push_back({1'b0, 32'h0000_0200, 32'h0, 4'b1111});
    exp_q.push_back({1'b1, 1'b0, 32'hFCFF_0300});
    exp_q.push_back({1'b0, 1'b0, 32'hFDFF_0200});
    fork
      run_master(1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b0011, 3, 0);
      run_master(0, 1'b0, 32'h0000_0200, 32'h0, 4'b1111, -1, 0);
    join

    // Immediate second pair: master 0 completed last, so master 1 wins again
    exp_s_q.push_back({1'b0, 32'h0000_0304, 32'h0, 4'b1100});
    exp_s_q.push_back({1'b0, 32'h0000_0204, 32'h0, 4'b1111});
    exp_q.push_back({1'b1, 1'b0, 32'hFCFB_0304});
    exp_q.push_back({1'b0, 1'b0, 32'hFDFB_0204});
    fork
      run_master(1, 1'b0, 32'h0000_0304, 32'h0, 4'b1100, 3, 0);
      run_master(0, 1'b0, 32'h0000_0204, 32'h0, 4'b1111, -1, 0);
    join

    // Solo master 1, then a pair: master 0 must now win
    exp_s_q.push_back({1'b0, 32'h0000_0308, 32'h0, 4'b1111});
    exp_q.push_back({1'b1, 1'b0, 32'hFCF7_0308});
    run_master(1, 1'b0, 32'h0000_0308, 32'h0, 4'b1111, 3, 1);
    exp_s_q.push_back({1'b1, 32'h0000_0208, 32'h0BAD_F00D, 4'b0001});
    exp_s_q.push_back({1'b0, 32'h0000_030C, 32'h0, 4'b1111});
    exp_q.push_back({1'b0, 1'b0, 32'hFDF7_0208});
    exp_q.push_back({1'b1, 1'b0, 32'hFCF3_030C});
    fork
      run_master(0, 1'b1, 32'h0000_0208, 32'h0BAD_F00D, 4'b0001, 3, 0);
      run_master(1, 1'b0, 32'h0000_030C, 32'h0, 4'b1111, -1, 0);
    join

    repeat (3) @(negedge clk);
    check("sb_queue_drained", 96'(exp_q.size()), 96'd0);
    check("slave_queue_drained", 96'(exp_s_q.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
